// File: rtl/frame_packer.sv
// frame_packer: packs WORDS input words MSB-first into one frame and strobes it
// to the serializer, never issuing two loads closer than HOLDOFF cycles apart.
module frame_packer #(
   parameter int WORD_W  = 16,
   parameter int WORDS   = 16,
   parameter int HOLDOFF = 17
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic [WORD_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WORD_W*WORDS-1:0]  out_data,
   output logic                     out_load,
   output logic [4:0]               fill_level,
   output logic [15:0]              frames_sent
);
   localparam int WIDTH = WORD_W * WORDS;
   localparam int HW    = $clog2(HOLDOFF) + 1;
   logic [WIDTH-1:0] asm;
   logic [4:0]       wr_idx;
   logic             asm_full;
   logic [HW-1:0]    hold;
   logic             accept;
   logic             xfer;
   assign in_ready   = rst_n && !asm_full;
   assign accept     = in_valid && in_ready && !clr;
   assign xfer       = asm_full && hold == '0 && !clr;
   assign fill_level = asm_full ? 5'(WORDS) : wr_idx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx      <= '0;
         asm_full    <= 1'b0;
         hold        <= '0;
         out_data    <= '0;
         out_load    <= 1'b0;
         frames_sent <= '0;
      end else begin
         out_load <= xfer;
         if (xfer) begin
            out_data    <= asm;
            hold        <= HW'(HOLDOFF - 1);
            frames_sent <= frames_sent + 16'd1;
         end else if (hold != '0) begin
            hold <= hold - 1'b1;
         end
         // clr wins over both a pending transfer and a same-edge final word
         if (clr || xfer) begin
            wr_idx   <= '0;
            asm_full <= 1'b0;
         end else if (accept) begin
            wr_idx   <= (wr_idx == 5'(WORDS - 1)) ? 5'd0 : wr_idx + 5'd1;
            asm_full <= wr_idx == 5'(WORDS - 1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (accept) asm[WIDTH-1-int'(wr_idx)*WORD_W -: WORD_W] <= in_data;
   end
endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: two packers (HOLDOFF 17 and 24) on shared stimulus, checked
// against a queue-of-words / earliest-load-cycle reference model.
module tb_frame_packer;
   localparam int W = 256;
   logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic rdy [2];
   logic ld [2];
   logic [W-1:0] od [2];
   logic [4:0] fl [2];
   logic [15:0] fs [2];
   int n_cmp = 0, n_bad = 0;
   logic [W-1:0] macc [2];
   logic [W-1:0] mdata [2];
   int mcnt [2];
   logic mload [2];
   logic [15:0] mfr [2];
   longint next_ok [2];
   longint last [2];
   longint ec = 0;
   int hold_of [2] = '{17, 24};
   int npulse [2];
   int nlow [2];
   int gap_last [2];
   always #5 clk = ~clk;
   frame_packer u_dut17 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[0]), .out_data(od[0]), .out_load(ld[0]), .fill_level(fl[0]), .frames_sent(fs[0]));
   frame_packer #(.HOLDOFF(24)) u_dut24 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy[1]), .out_data(od[1]), .out_load(ld[1]), .fill_level(fl[1]),
      .frames_sent(fs[1]));
   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         macc[i] = '0; mdata[i] = '0; mcnt[i] = 0; mload[i] = 1'b0;
         mfr[i] = '0; next_ok[i] = 0; last[i] = -1;
      end
   endtask
   // a frame is a shift of words into the low end; a load is allowed from next_ok on
   task automatic model_step();
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            logic x;
            x = mcnt[i] == 16 && ec >= next_ok[i] && !clr;
            mload[i] = x;
            if (x) begin
               mdata[i] = macc[i];
               mfr[i] = mfr[i] + 16'd1;
               next_ok[i] = ec + hold_of[i];
            end
            if (clr || x) mcnt[i] = 0;
            else if (in_valid && mcnt[i] != 16) begin
               macc[i] = {macc[i][W-17:0], in_data};
               mcnt[i]++;
            end
         end
      end
      ec++;
   endtask
   task automatic check_outputs();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("ready%0d", i), rdy[i], rst_n && mcnt[i] != 16);
         chk($sformatf("load%0d", i), ld[i], mload[i]);
         chk($sformatf("data%0d", i), od[i], mdata[i]);
         chk($sformatf("fill%0d", i), fl[i], mcnt[i]);
         chk($sformatf("frames%0d", i), fs[i], mfr[i]);
         if (ld[i]) begin
            if (last[i] >= 0) begin
               gap_last[i] = int'(ec - last[i]);
               chk($sformatf("spacing%0d", i), gap_last[i] >= hold_of[i], 1);
            end
            last[i] = ec;
            npulse[i]++;
         end
         if (rst_n && !rdy[i]) nlow[i]++;
      end
   endtask
   task automatic cycle(input logic r, input logic v, input logic [15:0] d, input logic c);
      @(negedge clk);
      rst_n = r; in_valid = v; in_data = d; clr = c;
      #1 check_outputs();
      @(posedge clk);
      model_step();
   endtask
   task automatic async_reset(input int n);
      #3 rst_n = 1'b0;
      #1 model_reset();
      check_outputs();
      repeat (n) cycle(1'b0, 1'b1, 16'($urandom), 1'b0);
   endtask
   initial begin
      logic [W-1:0] ef;
      model_reset();
      repeat (3) cycle(1'b0, 1'b1, 16'($urandom), 1'b0);
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
      for (int k = 1; k <= 16; k++) cycle(1'b1, 1'b1, 16'(k), 1'b0);
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
      #1;
      chk("single_load", ld[0], 1);
      chk("single_msw", od[0][255:240], 16'h0001);
      chk("single_lsw", od[0][15:0], 16'h0010);
      chk("single_frames", fs[0], 1);
      chk("single_fill", fl[0], 0);
      repeat (30) cycle(1'b1, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin npulse[i] = 0; nlow[i] = 0; gap_last[i] = 0; end
      for (int k = 0; k < 80; k++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
      chk("b2b_pulses17", npulse[0], 4);
      chk("b2b_pulses24", npulse[1], 3);
      chk("b2b_gap17", gap_last[0], 17);
      chk("b2b_gap24", gap_last[1], 24);
      chk("b2b_low17", nlow[0], 4);
      chk("b2b_low24", nlow[1], 17);
      repeat (40) cycle(1'b1, 1'b0, 16'h0, 1'b0);
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 16'(16'h0A00 + k), 1'b0);
      cycle(1'b1, 1'b1, 16'hDEAD, 1'b1);
      #1 chk("clr_fill", fl[0], 0);
      ef = '0;
      for (int k = 0; k < 16; k++) begin
         cycle(1'b1, 1'b1, 16'(16'h0100 + k), 1'b0);
         ef = {ef[W-17:0], 16'(16'h0100 + k)};
      end
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
      #1;
      chk("clr_load", ld[0], 1);
      chk("clr_frame", od[0], ef);
      for (int k = 0; k < 600; k++)
         cycle(1'b1, $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 49) == 0);
      begin
         int k;
         for (k = 0; k < 60 && !mload[0]; k++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
         chk("load_seen", mload[0], 1);
      end
      async_reset(3);
      for (int k = 0; k < 9; k++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
      #1 chk("fill9", fl[0], 9);
      async_reset(2);
      for (int k = 0; k < 15; k++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
      repeat (5) cycle(1'b1, 1'b0, 16'h0, 1'b0);
      chk("no_early_load", npulse[0] > 0 && last[0] > ec - 20, 0);
      cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
      repeat (30) cycle(1'b1, 1'b0, 16'h0, 1'b0);
      chk("post_rst_frames", fs[0], 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
